// File: rtl/pupil_locator_pkg.sv
// Shared constants, FSM state type and box-corner helper for the pupil locator.
package pupil_locator_pkg;

  localparam int CNT_W  = 21;
  localparam int SUM_W  = 34;
  localparam int POS_W  = 16;
  localparam int LUMA_W = 18;
  localparam int GRAY_W = 10;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_PUBLISH
  } state_t;

  // Box corner clamps at zero when the centroid sits closer than half a box to the edge.
  function automatic logic [POS_W-1:0] box_corner(input logic [POS_W-1:0] c,
                                                  input logic [POS_W-1:0] half);
    return (c >= half) ? (c - half) : '0;
  endfunction

endpackage

// File: rtl/pupil_locator_if.sv
// Pixel stream in and marker result out, grouped for the pupil locator.
interface pupil_locator_if;
  logic        iDVAL;
  logic [9:0]  iRed;
  logic [9:0]  iGreen;
  logic [9:0]  iBlue;
  logic [12:0] iH_Cont;
  logic [12:0] iV_Cont;
  logic [15:0] oPosX;
  logic [15:0] oPosY;
  logic        oValid;
  logic        oFound;
  logic        oDrop;
  logic        oBusy;

  modport master (
    output iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont,
    input  oPosX, oPosY, oValid, oFound, oDrop, oBusy
  );

  modport slave (
    input  iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont,
    output oPosX, oPosY, oValid, oFound, oDrop, oBusy
  );
endinterface

// File: rtl/pupil_locator_seq_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already resolves the MSB.
module seq_divider
  import pupil_locator_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  logic [CNT_W-1:0] rem_q;
  logic [SUM_W-1:0] quo_q;
  logic [CNT_W-1:0] div_q;
  logic [5:0]       steps_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] src_rem;
  logic [SUM_W-1:0] src_quo;
  logic [CNT_W-1:0] src_div;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   trial_sub;
  logic             fits;
  logic [CNT_W-1:0] rem_d;
  logic [SUM_W-1:0] quo_d;

  always_comb begin
    src_rem   = start ? '0 : rem_q;
    src_quo   = start ? dividend : quo_q;
    src_div   = start ? divisor : div_q;
    trial     = {src_rem, src_quo[SUM_W-1]};
    fits      = (trial >= {1'b0, src_div});
    trial_sub = trial - {1'b0, src_div};
    // The remainder after a step is always below the divisor, so it fits CNT_W bits.
    rem_d     = fits ? CNT_W'(trial_sub) : CNT_W'(trial);
    quo_d     = {src_quo[SUM_W-2:0], fits};
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= divisor;
      steps_q <= 6'(SUM_W - 1);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (busy_q) begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      steps_q <= steps_q - 6'd1;
      if (steps_q == 6'd1) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/pupil_locator.sv
// Per-frame dark-pixel centroid; publishes the marker box corner during the following frame.
module pupil_locator
  import pupil_locator_pkg::*;
#(
  parameter logic [9:0]       THRESH    = 10'd200,
  parameter logic [CNT_W-1:0] MIN_COUNT = 21'd64,
  parameter logic [POS_W-1:0] BOX_HALF  = 16'd20,
  parameter logic [12:0]      H_MAX     = 13'd1280,
  parameter logic [12:0]      V_MAX     = 13'd960
) (
  input  logic            iCLK,
  input  logic            iRST,
  pupil_locator_if.slave  bus
);

  logic [LUMA_W-1:0] luma_sum;
  logic [GRAY_W-1:0] gray_q;
  logic [12:0]       h1_q;
  logic [12:0]       v1_q;
  logic [12:0]       v1_prev_q;
  logic              dval1_q;

  logic [CNT_W-1:0]  cnt_q, cnt_snap_q;
  logic [SUM_W-1:0]  sumx_q, sumx_snap_q;
  logic [SUM_W-1:0]  sumy_q, sumy_snap_q;

  logic              boundary;
  logic              pix_hit;
  logic [CNT_W-1:0]  pix_inc;
  logic [SUM_W-1:0]  pix_x;
  logic [SUM_W-1:0]  pix_y;

  state_t            state_q, state_d;
  logic              div_start;
  logic              enough;
  logic [SUM_W-1:0]  quo_x, quo_y;
  logic              done_x, done_y;
  logic              valid_o, busy_o;

  logic [POS_W-1:0]  pos_x_q, pos_y_q;
  logic              found_q;
  logic              drop_q;

  assign luma_sum = LUMA_W'(COEF_R) * LUMA_W'(bus.iRed)
                  + LUMA_W'(COEF_G) * LUMA_W'(bus.iGreen)
                  + LUMA_W'(COEF_B) * LUMA_W'(bus.iBlue);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      gray_q    <= '0;
      h1_q      <= '0;
      v1_q      <= '0;
      v1_prev_q <= '0;
      dval1_q   <= 1'b0;
    end else begin
      gray_q    <= GRAY_W'(luma_sum >> 8);
      h1_q      <= bus.iH_Cont;
      v1_q      <= bus.iV_Cont;
      v1_prev_q <= v1_q;
      dval1_q   <= bus.iDVAL;
    end
  end

  // A falling line counter marks the first pixel of a new frame, whatever DVAL says.
  assign boundary = (v1_q < v1_prev_q);
  assign pix_hit  = dval1_q && (gray_q < THRESH) && (h1_q < H_MAX) && (v1_q < V_MAX);
  assign pix_inc  = CNT_W'(pix_hit);
  assign pix_x    = pix_hit ? SUM_W'(h1_q) : '0;
  assign pix_y    = pix_hit ? SUM_W'(v1_q) : '0;
  assign enough   = (cnt_snap_q >= MIN_COUNT);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q       <= '0;
      sumx_q      <= '0;
      sumy_q      <= '0;
      cnt_snap_q  <= '0;
      sumx_snap_q <= '0;
      sumy_snap_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= boundary && (state_q != ST_IDLE);
      if (boundary) begin
        cnt_q  <= pix_inc;
        sumx_q <= pix_x;
        sumy_q <= pix_y;
        // Snapshots stay frozen while a result is in flight; the dividers read them.
        if (state_q == ST_IDLE) begin
          cnt_snap_q  <= cnt_q;
          sumx_snap_q <= sumx_q;
          sumy_snap_q <= sumy_q;
        end
      end else begin
        cnt_q  <= cnt_q + pix_inc;
        sumx_q <= sumx_q + pix_x;
        sumy_q <= sumy_q + pix_y;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (boundary) state_d = ST_CHECK;
      ST_CHECK:   state_d = enough ? ST_DIVIDE : ST_IDLE;
      ST_DIVIDE:  if (done_x && done_y) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_start = (state_q == ST_CHECK) && enough;
    valid_o   = (state_q == ST_PUBLISH);
    busy_o    = (state_q != ST_IDLE);
  end

  seq_divider u_div_x (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .start    (div_start),
    .dividend (sumx_snap_q),
    .divisor  (cnt_snap_q),
    .quotient (quo_x),
    .done     (done_x)
  );

  seq_divider u_div_y (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .start    (div_start),
    .dividend (sumy_snap_q),
    .divisor  (cnt_snap_q),
    .quotient (quo_y),
    .done     (done_y)
  );

  // Position lands as PUBLISH begins so it lines up with the oValid strobe.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      found_q <= 1'b0;
    end else if ((state_q == ST_CHECK) && !enough) begin
      found_q <= 1'b0;
    end else if ((state_q == ST_DIVIDE) && done_x && done_y) begin
      pos_x_q <= box_corner(POS_W'(quo_x), BOX_HALF);
      pos_y_q <= box_corner(POS_W'(quo_y), BOX_HALF);
      found_q <= 1'b1;
    end
  end

  assign bus.oPosX  = pos_x_q;
  assign bus.oPosY  = pos_y_q;
  assign bus.oValid = valid_o;
  assign bus.oFound = found_q;
  assign bus.oDrop  = drop_q;
  assign bus.oBusy  = busy_o;

endmodule

// File: tb/tb_pupil_locator.sv
// Scoreboard bench: a frame-level centroid model predicts each published box corner.
module tb_pupil_locator;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;

  pupil_locator_if bus();

  pupil_locator dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  typedef struct {
    int x;
    int y;
    int t;
  } exp_t;

  exp_t exp_q[$];

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  longint m_cnt, m_sx, m_sy;
  int     last_v, free_cyc;
  int     exp_found, exp_px, exp_py;
  int     exp_drops = 0;
  int     seen_drops = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int corner(input longint sum, input longint cnt);
    int c;
    c = int'((sum / cnt) % 65536);
    return (c >= 20) ? c - 20 : 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    last_v = 0; free_cyc = 0;
    exp_found = 0; exp_px = 0; exp_py = 0;
  endtask

  // Frame end at boundary cycle t: publish, reject or drop depending on whether the block is free.
  task automatic frame_end(input int t);
    exp_t e;
    if (t < free_cyc) begin
      exp_drops++;
    end else if (m_cnt >= 64) begin
      e.x = corner(m_sx, m_cnt);
      e.y = corner(m_sy, m_cnt);
      e.t = t + 36;
      exp_q.push_back(e);
      exp_px = e.x; exp_py = e.y; exp_found = 1;
      free_cyc = t + 37;
    end else begin
      exp_found = 0;
      free_cyc = t + 2;
    end
    m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  task automatic drive(input int h, input int v, input int r, input int g, input int b, input int dv);
    int gray;
    @(negedge iCLK);
    bus.iH_Cont = 13'(h);
    bus.iV_Cont = 13'(v);
    bus.iRed    = 10'(r);
    bus.iGreen  = 10'(g);
    bus.iBlue   = 10'(b);
    bus.iDVAL   = dv[0];
    if (v < last_v) frame_end(cyc + 1);
    last_v = v;
    gray = (77 * r + 150 * g + 29 * b) / 256;
    if (dv != 0 && gray < 200 && h < 1280 && v < 960) begin
      m_cnt++; m_sx += h; m_sy += v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, last_v, 0, 0, 0, 0);
  endtask

  task automatic frame(input int h0, input int w, input int v0, input int nl,
                       input int rx0, input int rx1, input int ry0, input int ry1, input int dark_dv);
    for (int v = v0; v < v0 + nl; v++) begin
      for (int h = h0; h < h0 + w; h++) begin
        if (h >= rx0 && h <= rx1 && v >= ry0 && v <= ry1)
          drive(h, v, $urandom_range(0, 150), $urandom_range(0, 150), $urandom_range(0, 150), dark_dv);
        else
          drive(h, v, $urandom_range(700, 1023), $urandom_range(700, 1023), $urandom_range(700, 1023), 1);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_found"}, bus.oFound, exp_found);
    check({tag, "_posx"}, bus.oPosX, exp_px);
    check({tag, "_posy"}, bus.oPosY, exp_py);
    check({tag, "_busy"}, bus.oBusy, 0);
  endtask

  task automatic wrap(input string tag);
    drive(5, 0, 1023, 1023, 1023, 1);
    idle(45);
    check_outputs(tag);
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    if (bus.oDrop) seen_drops++;
    if (bus.oValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got oValid=1 with no result pending (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pub_posx", bus.oPosX, e.x);
        check("pub_posy", bus.oPosY, e.y);
        check("pub_latency", cyc, e.t);
        check("pub_found", bus.oFound, 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nl, h0, v0, rw, rh, rx, ry, dv;
    model_reset();
    bus.iDVAL = 1'b0; bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
    bus.iH_Cont = '0; bus.iV_Cont = '0;
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    check("rst_valid", bus.oValid, 0);
    check("rst_drop", bus.oDrop, 0);
    check_outputs("rst");
    iRST = 1'b1;

    frame(0, 64, 1, 8, -1, -1, -1, -1, 1);
    wrap("bright");

    frame(90, 30, 195, 20, 100, 109, 200, 209, 1);
    wrap("square");

    frame(0, 20, 1, 12, 10, 14, 5, 9, 1);
    wrap("small");

    frame(0, 20, 1, 16, 5, 14, 5, 14, 1);
    wrap("saturate");

    frame(0, 20, 1, 12, 2, 13, 2, 11, 0);
    for (int h = 1280; h < 1300; h++) drive(h, 13, 0, 0, 0, 1);
    wrap("excluded");

    frame(90, 30, 195, 20, 100, 109, 200, 209, 1);
    drive(5, 0, 1023, 1023, 1023, 1);
    for (int i = 0; i < 9; i++) drive(i, 5, 1023, 1023, 1023, 1);
    wrap("drop");
    check("drop_count", seen_drops, exp_drops);

    for (int k = 0; k < 6; k++) begin
      w  = $urandom_range(20, 40);
      nl = $urandom_range(8, 20);
      h0 = $urandom_range(0, 1270);
      v0 = $urandom_range(1, 930);
      rw = $urandom_range(3, w);
      rh = $urandom_range(3, nl);
      rx = h0 + $urandom_range(0, w - rw);
      ry = v0 + $urandom_range(0, nl - rh);
      dv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      frame(h0, w, v0, nl, rx, rx + rw - 1, ry, ry + rh - 1, dv);
      wrap("random");
    end

    frame(90, 30, 195, 20, 100, 109, 200, 209, 1);
    drive(5, 0, 1023, 1023, 1023, 1);
    idle(15);
    check("mid_busy", bus.oBusy, 1);
    @(negedge iCLK);
    iRST = 1'b0;
    exp_q.delete();
    model_reset();
    idle(3);
    check("midrst_valid", bus.oValid, 0);
    check_outputs("midrst");
    iRST = 1'b1;
    idle(50);
    check_outputs("after_rst");

    check("queue_empty", exp_q.size(), 0);
    check("drop_total", seen_drops, exp_drops);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pupil_locator.md
Name: pupil_locator

Overview:
- Upstream stage of the pupil-marker overlay in the camera pixel pipeline. Consumes the same raw RGB stream and H/V counters as the overlay stage.
- Per frame, thresholds luma to find dark pixels, accumulates their coordinates, and divides to get the centroid.
- Publishes the 40x40 marker box top-left corner to the overlay stage once per frame, during the following frame.

Parameters:
- THRESH, 10'd200, luma strictly below this counts as a dark pixel.
- MIN_COUNT, 21'd64, minimum dark-pixel count for a valid detection.
- BOX_HALF, 16'd20, offset subtracted from the centroid to get the box corner.
- H_MAX, 13'd1280, pixels with iH_Cont >= H_MAX are ignored.
- V_MAX, 13'd960, pixels with iV_Cont >= V_MAX are ignored.

Ports:
- iCLK in 1 pixel clock
- iRST in 1 async active-low reset
- iDVAL in 1 pixel valid
- iRed in 10 red sample
- iGreen in 10 green sample
- iBlue in 10 blue sample
- iH_Cont in 13 horizontal pixel counter
- iV_Cont in 13 vertical line counter
- oPosX out 16 box corner X
- oPosY out 16 box corner Y
- oValid out 1 one-cycle strobe when oPosX/oPosY update
- oFound out 1 high if the last completed frame met MIN_COUNT
- oDrop out 1 one-cycle strobe when a frame result is discarded
- oBusy out 1 divider active

Behaviour:
- Reset: clock iCLK; reset iRST, asynchronous, active-low. All outputs, accumulators and pipeline registers go to 0 and the FSM goes to IDLE. Reset mid-divide aborts the divide with no oValid.
- Stage 1 (registered):
  - gray = (77*R + 150*G + 29*B) >> 8.
  - The sum is 18 bits wide; gray is 10 bits.
  - H, V and DVAL are registered alongside gray.
- Frame boundary: asserted on the cycle when the stage-1 V is less than the previous stage-1 V (counter wrap). The comparison is evaluated every cycle, independent of DVAL.
- Stage 2 accumulate:
  - A stage-1 pixel is counted if DVAL=1, gray<THRESH, H<H_MAX and V<V_MAX.
  - Counting does: cnt += 1 (21 b), sum_x += H (34 b), sum_y += V (34 b).
- On a boundary:
  - cnt, sum_x and sum_y are snapshotted and the accumulators are cleared.
  - The boundary-cycle pixel, if counted, goes into the cleared accumulators, so no pixel is lost.
- FSM IDLE -> (boundary) CHECK -> DIVIDE -> PUBLISH -> IDLE:
  - CHECK, cnt_snap < MIN_COUNT: oFound<=0, oValid not asserted, oPosX/oPosY hold; return to IDLE.
  - CHECK, otherwise: start two parallel dividers, sum_x_snap/cnt_snap and sum_y_snap/cnt_snap.
  - DIVIDE: wait until both dividers report done.
  - PUBLISH:
    - cx = quotient truncated to 16 b.
    - oPosX = (cx >= BOX_HALF) ? cx - BOX_HALF : 0; oPosY is computed the same way from cy.
    - oFound<=1 and oValid=1 for one cycle.
- oBusy is high in CHECK, DIVIDE and PUBLISH.
- Boundary while not IDLE: the accumulators still snapshot and clear, but the snapshot is discarded. oDrop pulses one cycle and the in-progress result completes normally.
- Latency, boundary to oValid: 1 (CHECK) + 34 (divide) + 1 (PUBLISH) = 36 cycles. Vertical blanking covers this.
- Accumulator overflow cannot occur at H_MAX*V_MAX. cnt_snap=0 is never divided because MIN_COUNT >= 1.

Decomposition:
- Shared package:
  - luma coefficients 77/150/29.
  - the FSM state enum.
  - width constants: CNT_W=21, SUM_W=34, POS_W=16.
- Sub-module seq_divider:
  - Restoring divider, one quotient bit per cycle.
  - Ports: iCLK, iRST, start, dividend[33:0], divisor[20:0], quotient[33:0], done.
  - Instantiated twice.

Test Plan:
- Reset held for 5 cycles, then released -> all outputs 0, oBusy 0.
- Full frame, all pixels R=G=B=1023, then wrap -> no oValid, oFound=0, oPosX/oPosY unchanged.
- Dark square R=G=B=0 at H 100..109, V 200..209 (100 px), rest bright, then wrap -> oValid exactly 36 cycles after the boundary; oPosX=84 (104-20), oPosY=184; oFound=1.
- Dark 5x5 square at H 10..14, V 5..9 (25 px < 64) -> oFound=0, no oValid. Dark 10x10 at H 5..14, V 5..14 -> oPosX=0, oPosY=0 (saturation).
- Dark pixels presented with iDVAL=0, plus dark pixels at H>=1280 -> not counted; result equals the bright-frame case.
- Second V wrap 10 cycles after the first -> oDrop for one cycle, the first result still publishes. Separately, iRST asserted mid-DIVIDE -> no oValid, outputs 0.
